// File: rtl/reg_ctx_pkg.sv
// reg_ctx_pkg: shared constants for the register-context save/restore sequencer.
// Optional build macro REG_CTX_MASK_EN (per-register transfer mask) is handled
// in reg_ctx_seq; nothing here depends on it.
package reg_ctx_pkg;

  // Default geometry of the CPU register file and data memory
  localparam int NUM_REGS_DEF = 16;
  localparam int SEL_W_DEF    = 4;
  localparam int ADDR_W_DEF   = 16;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAVE    = 3'd1;
  localparam logic [2:0] ST_RESTORE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/reg_ctx_port_mux.sv
// reg_ctx_port_mux: selects who drives the register file ports.
// CPU decode passes straight through unless the sequencer owns the file, in
// which case the sequencer drives select/write/data and move/add are forced off.
// Behaviour is identical with or without REG_CTX_MASK_EN.
module reg_ctx_port_mux
  import reg_ctx_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             seq_own,
  input  logic [SEL_W-1:0] seq_a_select,
  input  logic [SEL_W-1:0] seq_b_select,
  input  logic             seq_write_en,
  input  logic [7:0]       seq_din,
  input  logic [SEL_W-1:0] cpu_a_select,
  input  logic [SEL_W-1:0] cpu_b_select,
  input  logic             cpu_write_en,
  input  logic             cpu_move,
  input  logic             cpu_add,
  input  logic [7:0]       cpu_din,
  output logic [SEL_W-1:0] rf_a_select,
  output logic [SEL_W-1:0] rf_b_select,
  output logic             rf_write_en,
  output logic             rf_move,
  output logic             rf_add,
  output logic [7:0]       rf_din
);

  // Ownership select; CPU inputs are fully ignored while the sequencer owns the file
  always_comb begin
    if (seq_own) begin
      rf_a_select = seq_a_select;
      rf_b_select = seq_b_select;
      rf_write_en = seq_write_en;
      rf_move     = 1'b0;
      rf_add      = 1'b0;
      rf_din      = seq_din;
    end else begin
      rf_a_select = cpu_a_select;
      rf_b_select = cpu_b_select;
      rf_write_en = cpu_write_en;
      rf_move     = cpu_move;
      rf_add      = cpu_add;
      rf_din      = cpu_din;
    end
  end

endmodule

// File: rtl/reg_ctx_seq.sv
// reg_ctx_seq: context save/restore sequencer for the CPU register file.
// Save streams r0..rN-1 to memory at base+i; restore streams memory back,
// with writes lagging reads by one cycle (memory read latency), closed by DRAIN.
// Build macro REG_CTX_MASK_EN adds ctx_mask: masked slots keep their cycle and
// address but suppress the memory write (save) or register write (restore).
module reg_ctx_seq
  import reg_ctx_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  input  logic [SEL_W-1:0]  cpu_a_select,
  input  logic [SEL_W-1:0]  cpu_b_select,
  input  logic              cpu_write_en,
  input  logic              cpu_move,
  input  logic              cpu_add,
  input  logic [7:0]        cpu_din,
  output logic [SEL_W-1:0]  rf_a_select,
  output logic [SEL_W-1:0]  rf_b_select,
  output logic              rf_write_en,
  output logic              rf_move,
  output logic              rf_add,
  output logic [7:0]        rf_din,
  input  logic [7:0]        rf_outB,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
`ifdef REG_CTX_MASK_EN
  ,
  input  logic [NUM_REGS-1:0] ctx_mask
`endif
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [SEL_W-1:0]  prev_idx;
  logic [ADDR_W-1:0] slot_addr;
  logic              save_slot_en;
  logic              rest_slot_en;

  logic              seq_own;
  logic [SEL_W-1:0]  seq_a_select;
  logic [SEL_W-1:0]  seq_b_select;
  logic              seq_write_en;
  logic [7:0]        seq_din;

  assign prev_idx  = idx_q - SEL_W'(1);
  // Wraps modulo 2^ADDR_W by construction
  assign slot_addr = base_q + ADDR_W'(idx_q);

`ifdef REG_CTX_MASK_EN
  logic [NUM_REGS-1:0] mask_q, mask_d;

  assign save_slot_en = mask_q[idx_q];
  // DRAIN writes the last register; RESTORE writes the one read last cycle
  assign rest_slot_en = (state_q == ST_DRAIN) ? mask_q[LAST_IDX] : mask_q[prev_idx];
`else
  assign save_slot_en = 1'b1;
  assign rest_slot_en = 1'b1;
`endif

  // Next-state, index and latched base/mask
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
`ifdef REG_CTX_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (save_req || restore_req) begin
          state_d = save_req ? ST_SAVE : ST_RESTORE;
          idx_d   = '0;
          base_d  = base_addr;
`ifdef REG_CTX_MASK_EN
          mask_d  = ctx_mask;
`endif
        end
      end
      ST_SAVE: begin
        if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                   idx_d   = idx_q + SEL_W'(1);
      end
      ST_RESTORE: begin
        if (idx_q == LAST_IDX) state_d = ST_DRAIN;
        else                   idx_d   = idx_q + SEL_W'(1);
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state outputs; writes are gated by reset so an abort takes effect
  // in the very cycle reset is raised rather than one edge later
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    seq_a_select = '0;
    seq_b_select = '0;
    seq_write_en = 1'b0;
    seq_din      = '0;
    case (state_q)
      ST_SAVE: begin
        busy         = 1'b1;
        seq_b_select = idx_q;
        mem_addr     = slot_addr;
        mem_wdata    = rf_outB;
        mem_we       = save_slot_en & ~reset;
      end
      ST_RESTORE: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = slot_addr;
        if (idx_q != '0) begin
          seq_a_select = prev_idx;
          seq_din      = mem_rdata;
          seq_write_en = rest_slot_en & ~reset;
        end
      end
      ST_DRAIN: begin
        busy         = 1'b1;
        seq_a_select = LAST_IDX;
        seq_din      = mem_rdata;
        seq_write_en = rest_slot_en & ~reset;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign seq_own = busy;

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
`ifdef REG_CTX_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
`ifdef REG_CTX_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  reg_ctx_port_mux #(.SEL_W(SEL_W)) u_port_mux (
    .seq_own      (seq_own),
    .seq_a_select (seq_a_select),
    .seq_b_select (seq_b_select),
    .seq_write_en (seq_write_en),
    .seq_din      (seq_din),
    .cpu_a_select (cpu_a_select),
    .cpu_b_select (cpu_b_select),
    .cpu_write_en (cpu_write_en),
    .cpu_move     (cpu_move),
    .cpu_add      (cpu_add),
    .cpu_din      (cpu_din),
    .rf_a_select  (rf_a_select),
    .rf_b_select  (rf_b_select),
    .rf_write_en  (rf_write_en),
    .rf_move      (rf_move),
    .rf_add       (rf_add),
    .rf_din       (rf_din)
  );

endmodule

// File: tb/tb_reg_ctx_seq.sv
// tb_reg_ctx_seq: directed bench for reg_ctx_seq with a behavioural register
// file and data memory. Mask test runs only when REG_CTX_MASK_EN is defined.
module tb_reg_ctx_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_req, restore_req;
  logic [15:0] base_addr;
  logic        busy, done;
  logic [3:0]  cpu_a_select, cpu_b_select;
  logic        cpu_write_en, cpu_move, cpu_add;
  logic [7:0]  cpu_din;
  logic [3:0]  rf_a_select, rf_b_select;
  logic        rf_write_en, rf_move, rf_add;
  logic [7:0]  rf_din, rf_outB;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
`ifdef REG_CTX_MASK_EN
  logic [15:0] ctx_mask;
`endif

  // bench-side memory preload port
  logic        tb_we;
  logic [15:0] tb_addr;
  logic [7:0]  tb_data;

  logic [7:0]  rf  [16];
  logic [7:0]  mem [65536];

  int checks = 0;
  int errors = 0;

  int we_cnt, re_cnt, rfwe_cnt, busy_cnt, done_cnt, done_cyc, rfwe_first;
  logic        busy_add1;
  logic [3:0]  busy_b1;
  logic [15:0] waddr [$];

  always #5 clk = ~clk;

  reg_ctx_seq dut (
    .clk          (clk),
    .reset        (reset),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .cpu_a_select (cpu_a_select),
    .cpu_b_select (cpu_b_select),
    .cpu_write_en (cpu_write_en),
    .cpu_move     (cpu_move),
    .cpu_add      (cpu_add),
    .cpu_din      (cpu_din),
    .rf_a_select  (rf_a_select),
    .rf_b_select  (rf_b_select),
    .rf_write_en  (rf_write_en),
    .rf_move      (rf_move),
    .rf_add       (rf_add),
    .rf_din       (rf_din),
    .rf_outB      (rf_outB),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata)
`ifdef REG_CTX_MASK_EN
    ,
    .ctx_mask     (ctx_mask)
`endif
  );

  // register file model: combinational B read, clocked write
  assign rf_outB = rf[rf_b_select];
  always @(posedge clk) if (rf_write_en) rf[rf_a_select] <= rf_din;

  // data memory model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr]  <= tb_data;
    if (mem_re)     mem_rdata     <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_poke(input logic [15:0] a, input logic [7:0] d);
    tb_addr = a; tb_data = d; tb_we = 1'b1;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic rf_poke(input logic [3:0] i, input logic [7:0] d);
    cpu_a_select = i; cpu_din = d; cpu_write_en = 1'b1;
    tick();
    cpu_write_en = 1'b0;
  endtask

  // issue request(s) and observe a fixed 24-cycle window after acceptance
  task automatic run(input logic sv, input logic rs, input logic [15:0] base);
    we_cnt = 0; re_cnt = 0; rfwe_cnt = 0; busy_cnt = 0; done_cnt = 0;
    done_cyc = 0; rfwe_first = 0; busy_add1 = 1'bx; busy_b1 = 4'hx;
    waddr.delete();
    save_req = sv; restore_req = rs; base_addr = base;
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      if (mem_we) begin we_cnt++; waddr.push_back(mem_addr); end
      if (mem_re) re_cnt++;
      if (rf_write_en) begin rfwe_cnt++; if (rfwe_first == 0) rfwe_first = n; end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = n; end
      if (n == 1) begin busy_add1 = rf_add; busy_b1 = rf_b_select; end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0; base_addr = 16'h0;
    cpu_a_select = 4'h0; cpu_b_select = 4'h5; cpu_write_en = 1'b0;
    cpu_move = 1'b0; cpu_add = 1'b0; cpu_din = 8'h0;
    tb_we = 1'b0; tb_addr = 16'h0; tb_data = 8'h0;
`ifdef REG_CTX_MASK_EN
    ctx_mask = 16'hFFFF;
`endif
    tick(); tick();

    // reset state
    chk("rst_busy",  busy,        1'b0);
    chk("rst_done",  done,        1'b0);
    chk("rst_we",    mem_we,      1'b0);
    chk("rst_re",    mem_re,      1'b0);
    chk("rst_addr",  mem_addr,    16'h0);
    chk("rst_wdata", mem_wdata,   8'h0);
    chk("rst_bsel",  rf_b_select, 4'h5);
    reset = 1'b0;
    tick();

    // save r_i = 0xA0+i to 0x1000
    for (int i = 0; i < 16; i++) rf_poke(4'(i), 8'(8'hA0 + i));
    run(1'b1, 1'b0, 16'h1000);
    for (int i = 0; i < 16; i++) chk("save_mem", mem[16'h1000 + i], 8'(8'hA0 + i));
    chk("save_we_cnt",   we_cnt,   16);
    chk("save_busy_cnt", busy_cnt, 16);
    chk("save_done_cyc", done_cyc, 17);
    chk("save_done_cnt", done_cnt, 1);
    chk("save_re_cnt",   re_cnt,   0);
    chk("save_addr0",    waddr[0], 16'h1000);

    // restore from 0x2000, mem = 0x5A^i
    for (int i = 0; i < 16; i++) mem_poke(16'h2000 + 16'(i), 8'(8'h5A ^ i));
    run(1'b0, 1'b1, 16'h2000);
    for (int i = 0; i < 16; i++) chk("rest_rf", rf[i], 8'(8'h5A ^ i));
    chk("rest_re_cnt",    re_cnt,     16);
    chk("rest_rfwe_cnt",  rfwe_cnt,   16);
    chk("rest_rfwe_lag",  rfwe_first, 2);
    chk("rest_busy_cnt",  busy_cnt,   17);
    chk("rest_done_cyc",  done_cyc,   18);

    // IDLE passthrough, then both requests at once with the same CPU inputs
    cpu_add = 1'b1; cpu_b_select = 4'h2;
    #1;
    chk("idle_add",  rf_add,      1'b1);
    chk("idle_bsel", rf_b_select, 4'h2);
    run(1'b1, 1'b1, 16'h3000);
    chk("busy_add",      busy_add1, 1'b0);
    chk("busy_bsel",     busy_b1,   4'h0);
    chk("dual_re_cnt",   re_cnt,    0);
    chk("dual_done_cnt", done_cnt,  1);
    chk("dual_we_cnt",   we_cnt,    16);
    chk("dual_mem3",     mem[16'h3003], 8'h59);
    cpu_add = 1'b0; cpu_b_select = 4'h0;

    // address wrap from 0xFFF8
    run(1'b1, 1'b0, 16'hFFF8);
    chk("wrap_n",     waddr.size(), 16);
    chk("wrap_a7",    waddr[7],     16'hFFFF);
    chk("wrap_a8",    waddr[8],     16'h0000);
    chk("wrap_a15",   waddr[15],    16'h0007);
    chk("wrap_mem0",  mem[16'h0000], 8'h52);
    chk("wrap_mem7",  mem[16'h0007], 8'h55);

    // reset at SAVE idx=5
    mem_poke(16'h4004, 8'hEE);
    mem_poke(16'h4005, 8'hEE);
    base_addr = 16'h4000; save_req = 1'b1;
    tick();
    save_req = 1'b0;
    repeat (5) tick();
    chk("abort_pre_we", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_we", mem_we, 1'b0);
    done_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (done) done_cnt++;
      if (n == 0) chk("abort_busy", busy, 1'b0);
    end
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_mem4", mem[16'h4004], 8'h5E);
    chk("abort_mem5", mem[16'h4005], 8'hEE);
    run(1'b1, 1'b0, 16'h4000);
    chk("resave_mem5",     mem[16'h4005], 8'h5F);
    chk("resave_done_cyc", done_cyc,      17);

`ifdef REG_CTX_MASK_EN
    // mask 0x00FF: only r0..r7 reach memory, full-length sequence
    mem_poke(16'h5007, 8'hEE);
    mem_poke(16'h5008, 8'hEE);
    ctx_mask = 16'h00FF;
    run(1'b1, 1'b0, 16'h5000);
    chk("mask_mem7",     mem[16'h5007], 8'h5D);
    chk("mask_mem8",     mem[16'h5008], 8'hEE);
    chk("mask_we_cnt",   we_cnt,        8);
    chk("mask_done_cyc", done_cyc,      17);
    ctx_mask = 16'hFFFF;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_ctx_seq.md
Name: reg_ctx_seq

Overview:
- Context save/restore sequencer for the 16x8 CPU register file.
- On request, takes ownership of the register file ports from the CPU decode logic.
- Save: streams r0..r(NUM_REGS-1) to data memory at base_addr+i.
- Restore: streams memory back into the registers.
- Used by interrupt entry/exit and by task switching. CPU is stalled via busy while the sequence runs.

Parameters:
- NUM_REGS, 16, number of registers transferred (indices 0..NUM_REGS-1).
- SEL_W, 4, register select width.
- ADDR_W, 16, data memory address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- save_req  in  1  start save (sampled in IDLE only)
- restore_req  in  1  start restore (sampled in IDLE only)
- base_addr  in  ADDR_W  memory base, latched at request acceptance
- busy  out  1  sequencer owns register file; CPU must stall
- done  out  1  one-cycle completion pulse
- cpu_a_select  in  SEL_W  CPU register file A select
- cpu_b_select  in  SEL_W  CPU register file B select
- cpu_write_en  in  1  CPU register file write enable
- cpu_move  in  1  CPU register file move control
- cpu_add  in  1  CPU register file add control
- cpu_din  in  8  CPU register file write data
- rf_a_select  out  SEL_W  to register file A select
- rf_b_select  out  SEL_W  to register file B select
- rf_write_en  out  1  to register file write enable
- rf_move  out  1  to register file move control
- rf_add  out  1  to register file add control
- rf_din  out  8  to register file write data
- rf_outB  in  8  register file B read data (combinational)
- mem_addr  out  ADDR_W  data memory address
- mem_wdata  out  8  data memory write data
- mem_we  out  1  data memory write enable
- mem_re  out  1  data memory read enable
- mem_rdata  in  8  data memory read data, valid 1 cycle after mem_re

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset:
  - State goes to IDLE; idx=0; latched base=0.
  - busy=0, done=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - rf_* pass through cpu_*.
- States: IDLE, SAVE, RESTORE, DRAIN, DONE.
- IDLE:
  - rf_* = cpu_* combinationally; memory outputs 0.
  - save_req=1 -> SAVE. Otherwise restore_req=1 -> RESTORE.
  - Save has priority if both requests are high; the restore request is dropped, not queued.
  - On acceptance: latch base_addr, set idx=0.
- SAVE (NUM_REGS cycles):
  - Drive rf_b_select=idx, mem_addr=base+idx, mem_wdata=rf_outB, mem_we=1.
  - idx==NUM_REGS-1 -> DONE; otherwise idx++.
- RESTORE (NUM_REGS cycles):
  - Drive mem_re=1, mem_addr=base+idx.
  - If idx>0: rf_write_en=1, rf_a_select=idx-1, rf_din=mem_rdata.
  - idx==NUM_REGS-1 -> DRAIN; otherwise idx++.
- DRAIN (1 cycle): rf_write_en=1, rf_a_select=NUM_REGS-1, rf_din=mem_rdata, mem_re=0 -> DONE.
- DONE (1 cycle): done=1, busy=0, rf_* pass through -> IDLE. Requests are not sampled in DONE.
- busy=1 in SAVE, RESTORE and DRAIN.
- While busy:
  - rf_move=0 and rf_add=0 forced.
  - rf_write_en is driven only by the sequencer; all cpu_* inputs are ignored.
- Latency:
  - Save: busy for NUM_REGS cycles; done in cycle NUM_REGS+1 after acceptance.
  - Restore: busy for NUM_REGS+1 cycles.
- Address arithmetic: base+idx, modulo 2^ADDR_W (wraps 0xFFFF -> 0x0000).
- Requests asserted while busy or in DONE are ignored; requesters must hold or re-request.
- Reset mid-operation:
  - Immediate abort; no further mem_we or rf_write_en.
  - done is not pulsed; writes already performed remain.

Optional Feature:
- Macro REG_CTX_MASK_EN.
- Defined: adds port ctx_mask (in, NUM_REGS bits), latched at acceptance.
  - A register whose mask bit is 0 still consumes its cycle and address slot.
  - Masked save slot: mem_we=0.
  - Masked restore slot: rf_write_en=0 (the read is still issued).
  - An all-zero mask still runs full length and pulses done.
- Undefined: no port; every register is transferred.

Decomposition:
- Package reg_ctx_pkg holds:
  - state encoding constants (IDLE=0, SAVE=1, RESTORE=2, DRAIN=3, DONE=4, 3-bit);
  - NUM_REGS, SEL_W and ADDR_W defaults.
- One sub-module, reg_ctx_port_mux: combinational CPU/sequencer select of the rf_* outputs, including the move/add forcing.
- The FSM, index counter and address adder stay in reg_ctx_seq.

Test Plan:
- Save: ri=0xA0+i, base_addr=0x1000, pulse save_req -> mem[0x1000..0x100F]=0xA0..0xAF; mem_we high 16 cycles; busy 16 cycles; done in cycle 17.
- Restore: mem[0x2000+i]=0x5A^i -> ri=0x5A^i after DRAIN; mem_re high 16 cycles; rf_write_en high 16 cycles, one cycle lagging.
- save_req and restore_req in the same cycle -> only the save runs; no mem_re observed; a single done pulse.
- base_addr=0xFFF8 save -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
- Reset asserted at SAVE idx=5:
  - only mem[base..base+4] written; busy=0 next cycle; done never asserted;
  - a subsequent save completes normally.
- IDLE passthrough vs busy forcing:
  - IDLE: cpu_add=1, cpu_b_select=2 -> rf_add=1, rf_b_select=2.
  - Busy with the same inputs: rf_add=0.
  - With REG_CTX_MASK_EN and ctx_mask=0x00FF: only r0..r7 are written to memory.
